// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time to the memory
// controller, buffers returned words with their PC in a small circular queue,
// and hands the queue head to the decoder. A redirect flushes the queue and
// retargets the PC; a word returning for a request made before a redirect is
// dropped.
module fetch_unit #(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        IF_MC_ask,
   output logic [31:0] IF_MC_Addr,
   input  logic        MC_IF_ok,
   input  logic [31:0] MC_IF_Inst,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   output logic        IF_ID_valid,
   output logic [31:0] IF_ID_Inst,
   output logic [31:0] IF_ID_PC,
   input  logic        ID_IF_ready
);

   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             state_r;
   logic [31:0]        pc_r;
   logic               ask_r;
   logic [31:0]        addr_r;
   logic               discard_r;
   logic [CNT_W-1:0]   count_r;
   logic [PTR_W-1:0]   head_r;
   logic [PTR_W-1:0]   tail_r;
   logic [31:0]        inst_q_r [QUEUE_DEPTH];
   logic [31:0]        pc_q_r   [QUEUE_DEPTH];

   logic               push_s;
   logic               pop_s;
   logic               unused_jump_lsb_s;

   // The redirect target is word aligned, so its two low bits are never used.
   assign unused_jump_lsb_s = ^jump_addr[1:0];

   assign IF_MC_ask   = ask_r;
   assign IF_MC_Addr  = addr_r;
   assign IF_ID_valid = (count_r != CNT_ZERO);
   assign IF_ID_Inst  = inst_q_r[head_r];
   assign IF_ID_PC    = pc_q_r[head_r];

   // Decide whether the queue pushes a returned word and/or pops the head this cycle.
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (rst_in && rdy_in && !jump_en) begin
         push_s = (state_r == ST_WAIT) && MC_IF_ok && !discard_r;
         pop_s  = (count_r != CNT_ZERO) && ID_IF_ready;
      end else begin
         push_s = 1'b0;
         pop_s  = 1'b0;
      end
   end

   // Store the returned word and its PC in the tail slot.
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         inst_q_r[tail_r] <= MC_IF_Inst;
         pc_q_r[tail_r]   <= pc_r;
      end
   end

   // Request FSM, PC, discard flag and queue bookkeeping.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_r   <= ST_IDLE;
         pc_r      <= 32'h0000_0000;
         ask_r     <= 1'b0;
         addr_r    <= 32'h0000_0000;
         discard_r <= 1'b0;
         count_r   <= CNT_ZERO;
         head_r    <= PTR_ZERO;
         tail_r    <= PTR_ZERO;
      end else if (rdy_in) begin
         if (jump_en) begin
            // Redirect: flush the queue; an in-flight word must not land.
            pc_r    <= {jump_addr[31:2], 2'b00};
            count_r <= CNT_ZERO;
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            case (state_r)
               ST_WAIT: begin
                  if (MC_IF_ok) begin
                     state_r   <= ST_IDLE;
                     ask_r     <= 1'b0;
                     discard_r <= 1'b0;
                  end else begin
                     discard_r <= 1'b1;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  ask_r   <= 1'b0;
               end
            endcase
         end else begin
            if (push_s) begin
               tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
               head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CNT_ONE;
               2'b01:   count_r <= count_r - CNT_ONE;
               default: count_r <= count_r;
            endcase
            case (state_r)
               ST_IDLE: begin
                  // Only ask when a free slot is guaranteed for the reply.
                  if (count_r < DEPTH_C) begin
                     ask_r   <= 1'b1;
                     addr_r  <= pc_r;
                     state_r <= ST_WAIT;
                  end else begin
                     ask_r <= 1'b0;
                  end
               end
               ST_WAIT: begin
                  if (MC_IF_ok) begin
                     ask_r     <= 1'b0;
                     state_r   <= ST_IDLE;
                     discard_r <= 1'b0;
                     if (!discard_r) begin
                        pc_r <= pc_r + 32'd4;
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  ask_r   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk_in;
   logic        rst_v, rdy_v, ok_v, jmp_v, ready_v;
   logic [31:0] inst_v, jaddr_v;
   logic        IF_MC_ask, IF_ID_valid;
   logic [31:0] IF_MC_Addr, IF_ID_Inst, IF_ID_PC;

   fetch_unit #(.QUEUE_DEPTH(DEPTH)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_v),
      .rdy_in      (rdy_v),
      .IF_MC_ask   (IF_MC_ask),
      .IF_MC_Addr  (IF_MC_Addr),
      .MC_IF_ok    (ok_v),
      .MC_IF_Inst  (inst_v),
      .jump_en     (jmp_v),
      .jump_addr   (jaddr_v),
      .IF_ID_valid (IF_ID_valid),
      .IF_ID_Inst  (IF_ID_Inst),
      .IF_ID_PC    (IF_ID_PC),
      .ID_IF_ready (ready_v)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   // Behavioural model state
   ent_t        q[$];
   logic [31:0] m_pc, m_addr;
   bit          m_ask, m_disc;
   bit          ask_last, ok_prev;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge applied to the model, from the fetch rules.
   task automatic model_update();
      int n;
      if (!rst_v) begin
         m_pc = 32'h0; m_addr = 32'h0; m_ask = 1'b0; m_disc = 1'b0;
         q.delete();
      end else if (rdy_v) begin
         n = q.size();
         if (jmp_v) begin
            if (m_ask) begin
               if (ok_v) begin m_ask = 1'b0; m_disc = 1'b0; end
               else m_disc = 1'b1;
            end
            m_pc = {jaddr_v[31:2], 2'b00};
            q.delete();
         end else begin
            if (n != 0 && ready_v) void'(q.pop_front());
            if (!m_ask) begin
               if (n < DEPTH) begin m_ask = 1'b1; m_addr = m_pc; end
            end else if (ok_v) begin
               if (m_disc) m_disc = 1'b0;
               else begin
                  q.push_back('{pc: m_pc, inst: inst_v});
                  m_pc = m_pc + 32'd4;
               end
               m_ask = 1'b0;
            end
         end
      end
   endtask

   // Advance one cycle, update the model, then compare all outputs.
   task automatic cyc();
      @(posedge clk_in);
      ask_last = m_ask;
      ok_prev  = ok_v;
      model_update();
      #1;
      chk("ask", {31'b0, IF_MC_ask}, {31'b0, m_ask});
      chk("addr", IF_MC_Addr, m_addr);
      chk("valid", {31'b0, IF_ID_valid}, {31'b0, (q.size() != 0)});
      if (q.size() != 0) begin
         chk("head_inst", IF_ID_Inst, q[0].inst);
         chk("head_pc", IF_ID_PC, q[0].pc);
      end
   endtask

   // Memory controller: fixed 1-cycle latency or random latency with stray pulses.
   task automatic drive_mem(input bit rnd);
      if (!rnd) begin
         ok_v   = ask_last && m_ask && !ok_prev;
         inst_v = 32'h0000_0013;
      end else begin
         if (m_ask) ok_v = !ok_prev && ($urandom_range(0, 1) == 1);
         else       ok_v = ($urandom_range(0, 15) == 0);
         inst_v = $urandom;
      end
   endtask

   task automatic do_reset();
      rst_v = 1'b0;
      drive_mem(1'b0);
      cyc();
      cyc();
      rst_v = 1'b1;
   endtask

   initial begin
      bit found;
      logic [31:0] saved_addr;
      rst_v = 1'b0; rdy_v = 1'b1; ok_v = 1'b0; jmp_v = 1'b0; ready_v = 1'b0;
      inst_v = 32'h0; jaddr_v = 32'h0;
      m_pc = 32'h0; m_addr = 32'h0; m_ask = 1'b0; m_disc = 1'b0;
      ask_last = 1'b0; ok_prev = 1'b0;

      // Reset state, then first request at address 0
      do_reset();
      chk("rst_ask", {31'b0, IF_MC_ask}, 32'd0);
      chk("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
      drive_mem(1'b0); cyc();
      chk("first_ask", {31'b0, IF_MC_ask}, 32'd1);
      chk("first_addr", IF_MC_Addr, 32'h0);

      // Four fetches at one per three cycles fill the queue
      for (int i = 0; i < 11; i++) begin drive_mem(1'b0); cyc(); end
      chk("fill_count", q.size(), 32'd4);
      for (int i = 0; i < 4; i++) chk("fill_pc", q[i].pc, 32'(i * 4));
      for (int i = 0; i < 3; i++) begin drive_mem(1'b0); cyc(); end
      chk("full_ask", {31'b0, IF_MC_ask}, 32'd0);
      chk("full_head_pc", IF_ID_PC, 32'h0);
      chk("full_head_inst", IF_ID_Inst, 32'h0000_0013);

      // One pop frees a slot; the next ask goes to 0x10
      ready_v = 1'b1; drive_mem(1'b0); cyc(); ready_v = 1'b0;
      chk("pop_count", q.size(), 32'd3);
      chk("pop_head_pc", IF_ID_PC, 32'h4);
      drive_mem(1'b0); cyc();
      chk("refill_ask", {31'b0, IF_MC_ask}, 32'd1);
      chk("refill_addr", IF_MC_Addr, 32'h10);
      for (int i = 0; i < 4; i++) begin drive_mem(1'b0); cyc(); end

      // Redirect while waiting on 0x8
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         drive_mem(1'b0);
         if (m_ask && m_addr == 32'h8 && !ok_v) found = 1'b1;
         else cyc();
      end
      chk("wait8_found", {31'b0, found}, 32'd1);
      jmp_v = 1'b1; jaddr_v = 32'h0000_1002; cyc(); jmp_v = 1'b0;
      chk("jmp_flush_valid", {31'b0, IF_ID_valid}, 32'd0);
      chk("jmp_hold_ask", {31'b0, IF_MC_ask}, 32'd1);
      drive_mem(1'b0); cyc();
      chk("drop_valid", {31'b0, IF_ID_valid}, 32'd0);
      chk("drop_ask", {31'b0, IF_MC_ask}, 32'd0);
      drive_mem(1'b0); cyc();
      chk("jmp_ask_addr", IF_MC_Addr, 32'h1000);
      drive_mem(1'b0); cyc();
      drive_mem(1'b0); cyc();
      chk("jmp_first_pc", IF_ID_PC, 32'h1000);

      // Redirect in the same cycle as the returned word
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         drive_mem(1'b0);
         if (ok_v) found = 1'b1;
         else cyc();
      end
      chk("ok_found", {31'b0, found}, 32'd1);
      jmp_v = 1'b1; jaddr_v = 32'h0000_2000; cyc(); jmp_v = 1'b0;
      chk("coinc_valid", {31'b0, IF_ID_valid}, 32'd0);
      chk("coinc_ask", {31'b0, IF_MC_ask}, 32'd0);
      drive_mem(1'b0); cyc();
      chk("coinc_ask2", {31'b0, IF_MC_ask}, 32'd1);
      chk("coinc_addr", IF_MC_Addr, 32'h2000);

      // Freeze mid-wait with ok, ready and a redirect all present
      saved_addr = m_addr;
      rdy_v = 1'b0; ready_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ok_v = 1'b1; inst_v = 32'hDEAD_BEEF; jmp_v = (i == 2);
         cyc();
         chk("frz_ask", {31'b0, IF_MC_ask}, 32'd1);
         chk("frz_addr", IF_MC_Addr, saved_addr);
      end
      rdy_v = 1'b1; ready_v = 1'b0; jmp_v = 1'b0;
      for (int i = 0; i < 6; i++) begin drive_mem(1'b0); cyc(); end
      chk("resume_pc", q[0].pc, 32'h2000);

      // PC wrap at the top of the address space
      drive_mem(1'b0); jmp_v = 1'b1; jaddr_v = 32'hFFFF_FFFE; cyc(); jmp_v = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         drive_mem(1'b0); cyc();
         if (q.size() != 0) found = 1'b1;
      end
      chk("wrap_found", {31'b0, found}, 32'd1);
      chk("wrap_head_pc", IF_ID_PC, 32'hFFFF_FFFC);
      drive_mem(1'b0); cyc();
      chk("wrap_ask", {31'b0, IF_MC_ask}, 32'd1);
      chk("wrap_addr", IF_MC_Addr, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst_v   = ($urandom_range(0, 199) != 0);
         rdy_v   = ($urandom_range(0, 9) != 0);
         ready_v = ($urandom_range(0, 2) == 0);
         jmp_v   = ($urandom_range(0, 29) == 0);
         jaddr_v = $urandom;
         drive_mem(1'b1);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
